// File: rtl/sq_opn_pkg.sv
// Shared widths, defaults and sequencer state encoding for the operator
// output accumulator.
package sq_opn_pkg;
    localparam int SLOT_W     = 13;
    localparam int SAMPLE_W   = 16;
    localparam int ACC_W      = 18;
    localparam int CNT_W      = 5;
    localparam int NSLOTS_DEF = 24;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        RUN  = 2'd1,
        EMIT = 2'd2
    } seq_state_t;
endpackage

// File: rtl/sq_sat.sv
// Combinational left shift by SHIFT followed by saturation to a signed
// OUT_W-bit result; sat flags that clamping took place.
module sq_sat #(
    parameter int IN_W  = 18,
    parameter int SHIFT = 2,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);
    // Headroom of 5 bits covers every shift up to 4 without wrap.
    localparam int EXT_W = IN_W + 5;
    localparam logic signed [EXT_W-1:0] MAXV =
        {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MINV =
        {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    function automatic logic [OUT_W:0] shift_sat(input logic signed [IN_W-1:0] x);
        logic signed [EXT_W-1:0] wide;
        wide = EXT_W'(x) <<< SHIFT;
        if (wide > MAXV) begin
            shift_sat = {1'b1, MAXV[OUT_W-1:0]};
        end else if (wide < MINV) begin
            shift_sat = {1'b1, MINV[OUT_W-1:0]};
        end else begin
            shift_sat = {1'b0, wide[OUT_W-1:0]};
        end
    endfunction

    logic [OUT_W:0] res;

    always_comb begin
        res  = shift_sat(din);
        dout = res[OUT_W-1:0];
        sat  = res[OUT_W];
    end
endmodule

// File: rtl/sq_opn_acc.sv
// Frame accumulator: sums carrier slot samples over NSLOTS slots, then emits
// one gain-shifted, saturated output sample a cycle after the last slot.
module sq_opn_acc
    import sq_opn_pkg::*;
#(
    parameter int NSLOTS = NSLOTS_DEF,
    parameter int GAIN   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic signed [SLOT_W-1:0]   linear,
    input  logic                       lin_valid,
    input  logic                       carrier,
    input  logic                       frame_sync,
    input  logic                       clear_clip,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       sample_valid,
    output logic                       clip,
    output logic [CNT_W-1:0]           slot_cnt
);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(NSLOTS - 1);

    seq_state_t                 state_q, state_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [ACC_W-1:0]    sum_q, sum_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       svld_q, svld_d;
    logic                       clip_q, clip_d;

    logic signed [ACC_W-1:0]    contrib;
    logic signed [SAMPLE_W-1:0] sat_val;
    logic                       sat_hit;
    logic                       emit;

    sq_sat #(
        .IN_W  (ACC_W),
        .SHIFT (GAIN),
        .OUT_W (SAMPLE_W)
    ) u_sat (
        .din  (sum_q),
        .dout (sat_val),
        .sat  (sat_hit)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        svld_d   = 1'b0;
        contrib  = carrier ? ACC_W'(linear) : '0;
        emit     = (state_q == EMIT);

        // Completed frame sum from the previous edge goes out now.
        if (emit) begin
            sample_d = sat_val;
            svld_d   = 1'b1;
            state_d  = RUN;
        end
        clip_d = (clip_q & ~clear_clip) | (emit & sat_hit);

        // Sync discards the partial frame and wins over a last-slot completion.
        if (frame_sync) begin
            state_d = RUN;
            if (lin_valid) begin
                acc_d = contrib;
                cnt_d = CNT_W'(1);
            end else begin
                acc_d = '0;
                cnt_d = '0;
            end
        end else if (lin_valid) begin
            if (cnt_q == LAST_SLOT) begin
                sum_d   = acc_q + contrib;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = EMIT;
            end else begin
                acc_d   = acc_q + contrib;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= SYNC;
            acc_q    <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            svld_q   <= 1'b0;
            clip_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            svld_q   <= svld_d;
            clip_q   <= clip_d;
        end
        sum_q <= sum_d;
    end

    assign sample       = sample_q;
    assign sample_valid = svld_q;
    assign clip         = clip_q;
    assign slot_cnt     = cnt_q;
endmodule

// File: tb/tb_sq_opn_acc.sv
// Self-checking bench: a frame-list reference model is compared with the
// accumulator every cycle, plus literal checks for the documented scenarios.
module tb_sq_opn_acc;
    localparam int NS = 24;
    localparam int GN = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic signed [12:0] linear = '0;
    logic               lin_valid = 1'b0;
    logic               carrier = 1'b0;
    logic               frame_sync = 1'b0;
    logic               clear_clip = 1'b0;
    logic signed [15:0] sample;
    logic               sample_valid;
    logic               clip;
    logic [4:0]         slot_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state: contributions received in the current frame.
    int frame[$];
    bit pending = 0;
    int pend_sum = 0;
    int m_sample = 0;
    bit m_valid = 0;
    bit m_clip = 0;

    always #5 clk = ~clk;

    sq_opn_acc #(.NSLOTS(NS), .GAIN(GN)) dut (
        .clk          (clk),
        .reset        (reset),
        .linear       (linear),
        .lin_valid    (lin_valid),
        .carrier      (carrier),
        .frame_sync   (frame_sync),
        .clear_clip   (clear_clip),
        .sample       (sample),
        .sample_valid (sample_valid),
        .clip         (clip),
        .slot_cnt     (slot_cnt)
    );

    function automatic int clamp16(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic model_step();
        int scaled;
        int s;
        bit emit_now;
        bit set_clip;
        if (reset) begin
            frame.delete();
            pending  = 0;
            m_sample = 0;
            m_valid  = 0;
            m_clip   = 0;
            return;
        end
        emit_now = pending;
        pending  = 0;
        set_clip = 0;
        m_valid  = emit_now;
        if (emit_now) begin
            scaled   = pend_sum * (1 << GN);
            m_sample = clamp16(scaled);
            set_clip = (m_sample != scaled);
        end
        m_clip = (m_clip && !clear_clip) || set_clip;
        if (frame_sync) begin
            frame.delete();
            if (lin_valid) frame.push_back(carrier ? int'(linear) : 0);
        end else if (lin_valid) begin
            frame.push_back(carrier ? int'(linear) : 0);
            if (frame.size() == NS) begin
                s = 0;
                foreach (frame[i]) s += frame[i];
                pend_sum = s;
                pending  = 1;
                frame.delete();
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("sample", int'(sample), m_sample);
        chk("sample_valid", int'(sample_valid), int'(m_valid));
        chk("clip", int'(clip), int'(m_clip));
        chk("slot_cnt", int'(slot_cnt), frame.size());
    endtask

    task automatic slot(input int v, input bit c, input bit fs = 0,
                        input bit cc = 0, input bit rst = 0);
        reset      = rst;
        lin_valid  = 1'b1;
        linear     = 13'(v);
        carrier    = c;
        frame_sync = fs;
        clear_clip = cc;
        cyc();
    endtask

    task automatic idle(input bit cc = 0);
        reset      = 1'b0;
        lin_valid  = 1'b0;
        carrier    = 1'b0;
        frame_sync = 1'b0;
        clear_clip = cc;
        cyc();
    endtask

    task automatic expect_frame(input int exp_s, input bit exp_c);
        bit found = 0;
        for (int i = 0; i < 4 && !found; i++) begin
            idle();
            if (sample_valid) found = 1;
        end
        chk("frame_seen", int'(found), 1);
        if (found) begin
            chk("lit_sample", int'(sample), exp_s);
            chk("lit_clip", int'(clip), int'(exp_c));
        end
    endtask

    initial begin
        // Reset state
        cyc();
        cyc();
        chk("rst_sample", int'(sample), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_clip", int'(clip), 0);
        chk("rst_slot_cnt", int'(slot_cnt), 0);
        idle();

        // 24 carriers of +100 -> 2400 << 2
        for (int s = 0; s < NS; s++) slot(100, 1'b1);
        expect_frame(9600, 1'b0);
        idle();
        chk("valid_one_cycle", int'(sample_valid), 0);

        // Positive saturation then clear
        for (int s = 0; s < NS; s++) slot(4095, 1'b1);
        expect_frame(32767, 1'b1);
        idle(1'b1);
        chk("clip_cleared", int'(clip), 0);

        // Negative saturation with alternating carrier
        for (int s = 0; s < NS; s++) slot(-4096, (s % 2) == 0);
        expect_frame(-32768, 1'b1);
        idle(1'b1);

        // Frame sync at slot 10 restarts the frame
        for (int s = 0; s < 10; s++) slot(1000, 1'b1);
        slot(10, 1'b1, 1'b1);
        chk("sync_slot_cnt", int'(slot_cnt), 1);
        for (int s = 1; s < NS; s++) slot(10, 1'b1);
        expect_frame(960, 1'b0);

        // Reset on the last-slot edge suppresses the emission
        for (int s = 0; s < NS - 1; s++) slot(50, 1'b1);
        slot(50, 1'b1, 1'b0, 1'b0, 1'b1);
        idle();
        chk("rst_last_valid", int'(sample_valid), 0);
        chk("rst_last_sample", int'(sample), 0);
        chk("rst_last_cnt", int'(slot_cnt), 0);
        idle();
        chk("rst_last_valid2", int'(sample_valid), 0);

        // Modulator-only frames with random gaps
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < NS; s++) begin
                repeat ($urandom_range(0, 5)) idle();
                slot(int'($urandom_range(0, 8191)) - 4096, 1'b0);
            end
            expect_frame(0, 1'b0);
        end

        // Frame sync while idle clears the partial frame
        for (int s = 0; s < 5; s++) slot(7, 1'b1);
        reset = 1'b0; lin_valid = 1'b0; frame_sync = 1'b1; clear_clip = 1'b0;
        cyc();
        chk("sync_idle_cnt", int'(slot_cnt), 0);

        // Randomised traffic
        for (int f = 0; f < 10; f++) begin
            for (int s = 0; s < NS; s++) begin
                int v;
                v = (f % 2 == 1) ? int'($urandom_range(0, 8191)) - 4096
                                 : int'($urandom_range(0, 600)) - 300;
                repeat ($urandom_range(0, 3)) idle($urandom_range(0, 15) == 0);
                slot(v, 1'(($urandom_range(0, 3)) != 0),
                     $urandom_range(0, 80) == 0,
                     $urandom_range(0, 15) == 0,
                     $urandom_range(0, 300) == 0);
            end
        end
        repeat (4) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sq_opn_acc.md
SQ_OPN_ACC -- requirements
Module: sq_opn_acc

Interface
REQ-001 Parameter NSLOTS, default 24, number of slot samples per output frame (6 channels x 4 operators).
REQ-002 Parameter GAIN, default 2, left shift applied to the frame sum before saturation (range 0..4).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 linear  input  13  signed slot output from sq_slot, two's complement.
REQ-006 lin_valid  input  1  linear holds a slot sample this cycle.
REQ-007 carrier  input  1  qualifies linear: 1 = slot is a carrier and is summed, 0 = modulator and is counted but not summed.
REQ-008 frame_sync  input  1  forces the current lin_valid cycle, or the next one, to be slot 0.
REQ-009 clear_clip  input  1  clears the clip flag.
REQ-010 sample  output  16  signed mixed output sample, held between updates.
REQ-011 sample_valid  output  1  one-cycle pulse when sample updates.
REQ-012 clip  output  1  sticky flag: a saturation occurred since the last clear.
REQ-013 slot_cnt  output  5  index of the next expected slot, 0..NSLOTS-1.

Function
REQ-014 Accumulator acc SHALL be 18-bit signed, sign-extending linear; 24 x (-4096) = -98304 fits without overflow.
REQ-015 Each lin_valid cycle SHALL add linear to acc if carrier=1, else add 0; slot_cnt SHALL increment by 1 either way.
REQ-016 On the lin_valid cycle with slot_cnt=NSLOTS-1 (last slot), the sum SHALL be (acc + this sample); acc SHALL load 0 and slot_cnt SHALL wrap to 0 on that edge.
REQ-017 The sum SHALL be shifted left by GAIN in 23-bit signed arithmetic and saturated to [-32768, 32767]; the result SHALL be registered into sample on the edge after the last-slot edge.
REQ-018 sample_valid SHALL be 1 exactly in the cycle in which the new sample value first appears, so latency from the last-slot lin_valid edge is 1 cycle.
REQ-019 When saturation happens, clip SHALL set on the same edge that updates sample.
REQ-020 clear_clip SHALL clear clip; if a set and a clear occur in the same cycle, set SHALL win.
REQ-021 frame_sync with lin_valid=1 SHALL treat that input as slot 0: acc loads its contribution, slot_cnt loads 1, and the partial frame is discarded with no sample_valid.
REQ-022 frame_sync with lin_valid=0 SHALL clear acc and slot_cnt to 0, with no sample_valid.
REQ-023 frame_sync SHALL override the last-slot completion in REQ-016 when both occur together.
REQ-024 Cycles with lin_valid=0 and frame_sync=0 SHALL leave acc, slot_cnt and sample unchanged; gaps between slots of any length are allowed.
REQ-025 Sequence states are SYNC (no frame seen since reset), RUN (counting) and EMIT (output pipeline stage). SYNC->RUN on the first lin_valid or frame_sync; RUN->EMIT on last slot; EMIT->RUN after 1 cycle.
REQ-026 In SYNC, lin_valid without frame_sync SHALL be accepted as slot 0.

Reset
REQ-027 While reset=1: sample=0, sample_valid=0, clip=0, slot_cnt=0, acc=0, state=SYNC.
REQ-028 reset SHALL take priority over every other input.
REQ-029 A reset asserted mid-frame SHALL discard the partial sum, and any sample pending in EMIT SHALL NOT be emitted.

Structure
REQ-030 A shared package sq_opn_pkg SHALL hold the slot width (13), the sample width (16), the NSLOTS default and the state encoding.
REQ-031 The saturating shift SHALL be a sub-module, sq_sat, that is purely combinational and parameterised by input width, shift and output width.
REQ-032 The implementation SHALL be a single clock domain with no latches.

Verification
REQ-033 24 carrier slots of linear=+100 -> 1 cycle after the last slot, sample=9600 (2400<<2), sample_valid for 1 cycle, clip=0.
REQ-034 24 carrier slots of +4095 -> sample=32767, clip=1; then clear_clip -> clip=0.
REQ-035 24 slots of -4096 with carrier alternating 1,0 -> sum -49152<<2 saturates -> sample=-32768, clip=1.
REQ-036 frame_sync asserted with lin_valid at slot 10 of a running frame -> no sample_valid; the next emission equals the sum of the 24 slots counted from the sync.
REQ-037 reset asserted on the last-slot edge -> no sample_valid; sample=0 and slot_cnt=0 the cycle after reset deasserts.
REQ-038 Random gaps of 0..5 idle cycles between lin_valid, with carrier=0 for all slots -> sample=0 every frame and frame period = 24 valid inputs.
